// File: rtl/dif_pair_sched_pkg.sv
// Shared helpers for the DIF pair scheduler: stage-length arithmetic and
// the FILL/PAIR state encoding.
package dif_pair_sched_pkg;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_PAIR = 1'b1
   } state_e;

   function automatic int stage_len(input int total_stages, input int stage);
      return 1 << (total_stages - stage);
   endfunction

   function automatic int stage_half(input int total_stages, input int stage);
      return stage_len(total_stages, stage) / 2;
   endfunction

   // Index width with a 1-bit floor so degenerate sizes still get a real vector.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/dif_pair_sched_pair_buf.sv
// Half-block sample store: registered write, asynchronous read.
module dif_pair_sched_pair_buf #(
   parameter int AW = 2,
   parameter int DW = 20
) (
   input  logic          mclk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   // Sized to the full address space so a single-entry buffer needs no special case.
   logic [DW-1:0] mem [(1 << AW)];

   always_ff @(posedge mclk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dif_pair_sched.sv
// Buffers the first half of each stage block, then emits aligned
// (x[n], x[n+HALF]) pairs with their pair index, one cycle after acceptance.
module dif_pair_sched
   import dif_pair_sched_pkg::*;
#(
   parameter int IN_W         = 10,
   parameter int STAGE        = 0,
   parameter int TOTAL_STAGES = 8,
   localparam int STAGE_FFT_LEN = stage_len(TOTAL_STAGES, STAGE),
   localparam int HALF          = stage_half(TOTAL_STAGES, STAGE),
   localparam int IDX_W         = idx_w(HALF)
) (
   input  logic                   mclk,
   input  logic                   i_init,
   input  logic                   i_vld,
   input  logic signed [IN_W-1:0] i_I,
   input  logic signed [IN_W-1:0] i_Q,
   output logic                   o_vld,
   output logic signed [IN_W-1:0] o_LI,
   output logic signed [IN_W-1:0] o_LQ,
   output logic signed [IN_W-1:0] o_RI,
   output logic signed [IN_W-1:0] o_RQ,
   output logic [IDX_W-1:0]       o_pair_idx,
   output logic                   o_blk_last,
   output logic                   o_fill
);

   localparam int CNT_W = idx_w(STAGE_FFT_LEN);

   state_e            state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  wr_addr;
   logic [IDX_W-1:0]  rd_addr;
   logic [2*IN_W-1:0] rd_data;
   logic              buf_we;
   logic              cnt_at_half_m1;
   logic              cnt_at_last;

   assign wr_addr        = cnt[IDX_W-1:0];
   assign rd_addr        = IDX_W'(cnt - CNT_W'(HALF));
   assign buf_we         = i_vld & ~i_init & (state == ST_FILL);
   assign cnt_at_half_m1 = (cnt == CNT_W'(HALF - 1));
   assign cnt_at_last    = (cnt == CNT_W'(STAGE_FFT_LEN - 1));
   assign o_fill         = (state == ST_FILL);

   dif_pair_sched_pair_buf #(
      .AW (IDX_W),
      .DW (2 * IN_W)
   ) u_pair_buf (
      .mclk  (mclk),
      .we    (buf_we),
      .waddr (wr_addr),
      .wdata ({i_I, i_Q}),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge mclk) begin
      if (i_init) begin
         state      <= ST_FILL;
         cnt        <= '0;
         o_vld      <= 1'b0;
         o_blk_last <= 1'b0;
         o_pair_idx <= '0;
         o_LI       <= '0;
         o_LQ       <= '0;
         o_RI       <= '0;
         o_RQ       <= '0;
      end else begin
         // Pair strobes are single-cycle; data fields hold between pairs.
         o_vld      <= 1'b0;
         o_blk_last <= 1'b0;
         if (i_vld) begin
            cnt <= cnt + 1'b1;
            case (state)
               ST_FILL: begin
                  if (cnt_at_half_m1) begin
                     state <= ST_PAIR;
                  end
               end
               ST_PAIR: begin
                  o_vld      <= 1'b1;
                  o_blk_last <= cnt_at_last;
                  o_pair_idx <= (HALF == 1) ? '0 : rd_addr;
                  o_LI       <= rd_data[2*IN_W-1:IN_W];
                  o_LQ       <= rd_data[IN_W-1:0];
                  o_RI       <= i_I;
                  o_RQ       <= i_Q;
                  if (cnt_at_last) begin
                     state <= ST_FILL;
                  end
               end
               default: state <= ST_FILL;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dif_pair_sched.sv
// Directed bench for dif_pair_sched: a length-8 stage (u_dut_a) and the
// single-entry final stage (u_dut_b) share data/init but have separate valids.
module tb_dif_pair_sched;

   typedef struct packed {
      logic [9:0] li;
      logic [9:0] lq;
      logic [9:0] ri;
      logic [9:0] rq;
      logic [1:0] idx;
      logic       last;
   } pair_t;

   logic       mclk = 1'b0;
   logic       init = 1'b0;
   logic       vld_a = 1'b0;
   logic       vld_b = 1'b0;
   logic [9:0] in_i = '0;
   logic [9:0] in_q = '0;

   logic       a_vld, a_last, a_fill;
   logic [9:0] a_li, a_lq, a_ri, a_rq;
   logic [1:0] a_idx;
   logic       b_vld, b_last, b_fill;
   logic [9:0] b_li, b_lq, b_ri, b_rq;
   logic [0:0] b_idx;

   pair_t exp_a_q[$];
   pair_t exp_b_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    pulses_a = 0;

   always #5 mclk = ~mclk;

   dif_pair_sched #(.IN_W(10), .STAGE(5), .TOTAL_STAGES(8)) u_dut_a (
      .mclk(mclk), .i_init(init), .i_vld(vld_a), .i_I(in_i), .i_Q(in_q),
      .o_vld(a_vld), .o_LI(a_li), .o_LQ(a_lq), .o_RI(a_ri), .o_RQ(a_rq),
      .o_pair_idx(a_idx), .o_blk_last(a_last), .o_fill(a_fill)
   );

   dif_pair_sched #(.IN_W(10), .STAGE(7), .TOTAL_STAGES(8)) u_dut_b (
      .mclk(mclk), .i_init(init), .i_vld(vld_b), .i_I(in_i), .i_Q(in_q),
      .o_vld(b_vld), .o_LI(b_li), .o_LQ(b_lq), .o_RI(b_ri), .o_RQ(b_rq),
      .o_pair_idx(b_idx), .o_blk_last(b_last), .o_fill(b_fill)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, expv, $time);
      end
   endtask

   task automatic push_exp(input bit sel, input int li, input int lq, input int ri,
                           input int rq, input int idx, input bit last);
      pair_t e;
      e.li = li[9:0]; e.lq = lq[9:0]; e.ri = ri[9:0]; e.rq = rq[9:0];
      e.idx = idx[1:0]; e.last = last;
      if (sel) exp_b_q.push_back(e);
      else     exp_a_q.push_back(e);
   endtask

   // Expected pair for a stream where Q = -I.
   task automatic push_neg(input bit sel, input int l, input int r, input int idx, input bit last);
      push_exp(sel, l, -l, r, -r, idx, last);
   endtask

   task automatic send(input bit sel, input int i, input int q, input bit exp_vld);
      in_i = i[9:0];
      in_q = q[9:0];
      if (sel) vld_b = 1'b1;
      else     vld_a = 1'b1;
      @(posedge mclk);
      #1;
      vld_a = 1'b0;
      vld_b = 1'b0;
      check(sel ? "b_lat_vld" : "a_lat_vld", {31'b0, sel ? b_vld : a_vld}, {31'b0, exp_vld});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge mclk);
         #1;
         check("gap_quiet", {31'b0, a_vld | b_vld}, 32'd0);
      end
   endtask

   task automatic do_reset();
      init = 1'b1;
      @(posedge mclk);
      #1;
      init = 1'b0;
      check("rst_vld",  {30'b0, a_vld, b_vld}, 32'd0);
      check("rst_last", {30'b0, a_last, b_last}, 32'd0);
      check("rst_fill", {30'b0, a_fill, b_fill}, 32'd3);
      check("rst_data_a", {2'b0, a_li, a_lq, a_ri}, 32'd0);
      check("rst_rq_idx", {19'b0, a_rq, a_idx, b_idx}, 32'd0);
      check("rst_data_b", {2'b0, b_li, b_lq, b_ri}, 32'd0);
   endtask

   always @(negedge mclk) begin
      pair_t e;
      if (a_vld) begin
         pulses_a++;
         if (exp_a_q.size() == 0) check("a_unexpected_pair", 32'd1, 32'd0);
         else begin
            e = exp_a_q.pop_front();
            check("a_L", {12'b0, a_li, a_lq}, {12'b0, e.li, e.lq});
            check("a_R", {12'b0, a_ri, a_rq}, {12'b0, e.ri, e.rq});
            check("a_idx_last", {29'b0, a_idx, a_last}, {29'b0, e.idx, e.last});
         end
      end
      if (b_vld) begin
         if (exp_b_q.size() == 0) check("b_unexpected_pair", 32'd1, 32'd0);
         else begin
            e = exp_b_q.pop_front();
            check("b_L", {12'b0, b_li, b_lq}, {12'b0, e.li, e.lq});
            check("b_R", {12'b0, b_ri, b_rq}, {12'b0, e.ri, e.rq});
            check("b_idx_last", {29'b0, 1'b0, b_idx, b_last}, {29'b0, e.idx, e.last});
         end
      end
   end

   initial begin
      idle(2);

      // Continuous single block: pairs (0,4)..(3,7).
      do_reset();
      pulses_a = 0;
      for (int n = 0; n < 4; n++) push_neg(0, n, n + 4, n, n == 3);
      for (int k = 0; k < 8; k++) send(0, k, -k, k >= 4);
      idle(2);
      check("t1_pulses", pulses_a, 32'd4);
      check("t1_drain", exp_a_q.size(), 32'd0);

      // Same stream with random gaps.
      do_reset();
      for (int n = 0; n < 4; n++) push_neg(0, n, n + 4, n, n == 3);
      for (int k = 0; k < 8; k++) begin
         idle($urandom_range(0, 2));
         send(0, k, -k, k >= 4);
      end
      idle(2);
      check("t2_drain", exp_a_q.size(), 32'd0);

      // Two back-to-back blocks.
      do_reset();
      for (int n = 0; n < 4; n++) push_neg(0, n, n + 4, n, n == 3);
      for (int n = 0; n < 4; n++) push_neg(0, n + 8, n + 12, n, n == 3);
      for (int k = 0; k < 16; k++) send(0, k, -k, (k % 8) >= 4);
      idle(2);
      check("t3_drain", exp_a_q.size(), 32'd0);
      check("t3_fill_after_block", {31'b0, a_fill}, 32'd1);

      // Flush mid-block, then a fresh block.
      do_reset();
      push_neg(0, 0, 4, 0, 0);
      push_neg(0, 1, 5, 1, 0);
      for (int k = 0; k < 6; k++) send(0, k, -k, k >= 4);
      do_reset();
      for (int n = 0; n < 4; n++) push_neg(0, 100 + n, 104 + n, n, n == 3);
      for (int k = 0; k < 8; k++) send(0, 100 + k, -(100 + k), k >= 4);
      idle(2);
      check("t4_drain", exp_a_q.size(), 32'd0);

      // Init wins over a valid sample at cnt = HALF-1.
      do_reset();
      for (int k = 0; k < 3; k++) send(0, k, -k, 1'b0);
      in_i = 10'd55;
      vld_a = 1'b1;
      init = 1'b1;
      @(posedge mclk);
      #1;
      vld_a = 1'b0;
      init = 1'b0;
      check("t5_init_vld", {31'b0, a_vld}, 32'd0);
      check("t5_init_fill", {31'b0, a_fill}, 32'd1);
      for (int n = 0; n < 4; n++) push_neg(0, 20 + n, 24 + n, n, n == 3);
      for (int k = 0; k < 8; k++) send(0, 20 + k, -(20 + k), k >= 4);
      idle(2);
      check("t5_drain", exp_a_q.size(), 32'd0);

      // Final stage, HALF = 1: pairs (0,1),(2,3),(4,5).
      do_reset();
      for (int n = 0; n < 3; n++) push_neg(1, 2 * n, 2 * n + 1, 0, 1'b1);
      for (int k = 0; k < 6; k++) send(1, k, -k, (k % 2) == 1);
      idle(2);
      check("t6_drain", exp_b_q.size(), 32'd0);

      // Full-scale values pass bit-exact.
      do_reset();
      push_exp(0, -512, 511, 511, -512, 0, 0);
      for (int n = 1; n < 4; n++) push_exp(0, 0, 0, 0, 0, n, n == 3);
      send(0, -512, 511, 1'b0);
      for (int k = 1; k < 4; k++) send(0, 0, 0, 1'b0);
      send(0, 511, -512, 1'b1);
      for (int k = 5; k < 8; k++) send(0, 0, 0, 1'b1);
      idle(2);
      check("t7_drain", exp_a_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dif_pair_sched.md
Name: dif_pair_sched

Overview:
- Front-end scheduler for one radix-2 DIF butterfly stage of the pipelined FFT.
- Accepts a serial complex stream, one sample per valid cycle.
- Buffers the first half of each stage block of STAGE_FFT_LEN samples.
- Then presents aligned L/R pairs (x[n], x[n+HALF]) plus the pair index, which drives the butterfly's valid/L/R inputs and its twiddle count.

Parameters:
- IN_W, 10, sample component width (signed I and Q).
- STAGE, 0, stage number within the FFT.
- TOTAL_STAGES, 8, log2 of the full FFT length.
- STAGE_FFT_LEN, localparam 2**(TOTAL_STAGES-STAGE), block length handled by this stage.
- HALF, localparam STAGE_FFT_LEN/2, buffer depth.
- IDX_W, localparam max(1, $clog2(HALF)), pair index width.

Ports:
- mclk  in  1  clock; all logic on the rising edge.
- i_init  in  1  synchronous active-high reset/flush.
- i_vld  in  1  input sample valid; no backpressure, sample accepted whenever high.
- i_I  in  IN_W  input sample, real part, signed.
- i_Q  in  IN_W  input sample, imaginary part, signed.
- o_vld  out  1  output pair valid.
- o_LI, o_LQ  out  IN_W each  L operand (buffered sample x[n]).
- o_RI, o_RQ  out  IN_W each  R operand (live sample x[n+HALF]).
- o_pair_idx  out  IDX_W  n within the block (0..HALF-1); tied to 0 when HALF=1.
- o_blk_last  out  1  high with the final pair of a block (pair_idx=HALF-1).
- o_fill  out  1  high while the scheduler is in FILL state (status only).

Behaviour:
- Reset (i_init=1 at a clock edge):
  - State goes to FILL and the sample counter cnt goes to 0.
  - o_vld=0, o_blk_last=0, o_pair_idx=0, all data outputs 0, o_fill=1.
  - Buffer contents are don't-care.
  - i_init has priority over i_vld in the same cycle; that sample is dropped.
- Counter:
  - cnt has width $clog2(STAGE_FFT_LEN), minimum 1 bit.
  - It increments only on accepted samples (i_vld & ~i_init).
  - It wraps from STAGE_FFT_LEN-1 to 0.
  - Gaps in i_vld hold all state; pairing remains correct across arbitrary gaps.
- FSM has 2 states:
  - FILL (cnt < HALF): an accepted sample is written to buf[cnt[IDX_W-1:0]]. o_vld stays 0. On writing index HALF-1, go to PAIR.
  - PAIR (cnt >= HALF): an accepted sample is paired with buf[cnt-HALF]. On the pair with cnt=STAGE_FFT_LEN-1, go to FILL.
- Pair output register, loaded on each accepted PAIR sample:
  - o_LI/o_LQ = buf[cnt-HALF].
  - o_RI/o_RQ = i_I/i_Q.
  - o_pair_idx = cnt-HALF.
  - o_blk_last = (cnt == STAGE_FFT_LEN-1).
- Latency and output timing:
  - Latency is exactly 1 cycle from the accepting edge to o_vld=1.
  - o_vld pulses 1 cycle per pair.
  - Data outputs hold their last value when o_vld=0.
- Buffer read:
  - The read is asynchronous from a register array.
  - The same location is never read and written in the same cycle, because FILL and PAIR are exclusive.
- Back-to-back blocks:
  - The first FILL write of block k+1 may coincide with the o_vld of block k's last pair. No bubble is required.
- Degenerate case HALF=1 (final stage):
  - Single-entry buffer.
  - Alternating FILL/PAIR per sample.
  - o_pair_idx is constant 0.
- Values pass through unmodified; there is no arithmetic on data, and width is preserved.
- Throughput: one pair per two input samples, averaged over a block.

Decomposition:
- Shared fft_pkg holds:
  - Stage-length helper functions (stage_len, stage_half, idx_w).
  - The FILL/PAIR state encoding constant.
- One natural sub-module: pair_buf, a HALF x 2*IN_W register array with write enable/address and an asynchronous read port.
- The FSM, counter and output registers stay in dif_pair_sched.

Test Plan:
- STAGE=5, TOTAL_STAGES=8 (len 8), continuous i_vld, I=0..7, Q=-I:
  - Exactly 4 pulses on o_vld, starting 5 cycles after the first sample.
  - Pairs are (0,4),(1,5),(2,6),(3,7) with idx 0..3.
  - o_blk_last only on (3,7).
- Same stream with i_vld toggling 1-0-0-1 randomly:
  - Identical pair sequence and indices.
  - Each o_vld arrives exactly 1 cycle after the accepting edge.
- Two back-to-back blocks, I=0..15:
  - The second block yields (8,12)..(11,15).
  - No pair mixes samples across blocks.
- i_init asserted after 6 samples, then samples 100..107:
  - o_vld=0 and outputs 0 the cycle after reset.
  - The next pairs are (100,104)..(103,107).
- i_init and i_vld high together on the cycle where cnt=HALF-1:
  - The sample is dropped, state is FILL with cnt=0, and no o_vld follows.
- STAGE=TOTAL_STAGES-1 (HALF=1), I=0..5 continuous:
  - Pairs are (0,1),(2,3),(4,5).
  - Idx is always 0 and o_blk_last=1 on every pair.
- IN_W extremes, pair (-512,511) with IN_W=10:
  - Outputs are bit-exact with sign preserved.
